// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the 8N1 UART receive sink.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_HIGH,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_rx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Rounded to the nearest integer so the sample point drifts as little as possible.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with a registered head word; push is accepted when full only alongside a pop.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic                       o_full,
    input  logic                       i_pop,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [WIDTH-1:0]           o_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             push_en;
    logic             pop_en;

    assign o_full  = (count_q == FULL_CNT);
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_rdata = rdata_q;
    assign rd_next = rd_ptr_q + AW'(1);

    always_comb begin
        pop_en   = i_pop && (count_q != '0);
        push_en  = i_push && ((count_q != FULL_CNT) || pop_en);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + AW'(push_en);
        rd_ptr_d = rd_ptr_q + AW'(pop_en);
        count_d  = count_q;
        rdata_d  = rdata_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = i_wdata;
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Head register tracks the oldest word; it reads the slot after rd_ptr because
        // a full push+pop may overwrite the slot being popped.
        if (push_en && (count_q == '0)) begin
            rdata_d = i_wdata;
        end else if (pop_en) begin
            if (count_q > CW'(1)) begin
                rdata_d = mem_q[rd_next];
            end else if (push_en) begin
                rdata_d = i_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: rtl/uart_rx_sink.sv
// 8N1 UART receiver: synchronizer, bit-timing FSM and shift register feeding a byte FIFO.
module uart_rx_sink
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_rx,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_busy,
    output logic                          o_frame_err,
    output logic                          o_overrun
);

    localparam int CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    uart_rx_state_t         state_q, state_d;
    logic                   rx_meta_q, rx_meta_d;
    logic                   rx_s_q, rx_s_d;
    logic [1:0]             sync_fill_q, sync_fill_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign o_valid     = !fifo_empty;
    assign pop         = o_valid && i_ready;
    assign o_busy      = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

    always_comb begin
        rx_meta_d   = i_rx;
        rx_s_d      = rx_meta_q;
        // The synchronizer holds reset values for two cycles; don't trust rx_s until it is refilled.
        sync_fill_d = {sync_fill_q[0], 1'b1};
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        push        = 1'b0;
        case (state_q)
            ST_WAIT_HIGH: begin
                if (sync_fill_q[1] && rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push      = 1'b1;
                        overrun_d = fifo_full && !pop;
                        state_d   = ST_IDLE;
                    end else begin
                        // Stop bit low: treat as break, wait for the line to recover.
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT_HIGH;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            sync_fill_q <= 2'b00;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            sync_fill_q <= sync_fill_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (push),
        .i_wdata (shift_q),
        .o_full  (fifo_full),
        .i_pop   (pop),
        .o_empty (fifo_empty),
        .o_count (o_count),
        .o_rdata (o_data)
    );

endmodule
